// File: rtl/pic_int_sequencer_pkg.sv
// Shared types and constants for the PIC interrupt sequencer: FSM states, OCW2 command codes,
// reset/spurious levels, and priority helpers.
package pic_int_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK1 = 1'b1
    } state_t;

    // OCW2 {R,SL,EOI} command codes
    localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    localparam logic [2:0] LP_RESET          = 3'd7;
    localparam logic [2:0] SPURIOUS_LVL_DFLT = 3'd7;

    // 0 = highest priority given the current lowest-priority pointer
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/pic_int_sequencer_priority_resolver.sv
// Combinational rotating priority encoder: returns the highest-priority set bit of i_req,
// where level (i_lp+1) mod 8 ranks highest and priority descends with wrap.
module pic_priority_resolver (
    input  logic [7:0] i_req,
    input  logic [2:0] i_lp,
    output logic       o_valid,
    output logic [2:0] o_lvl
);
    logic [2:0]  w_start;
    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_idx;

    always_comb begin
        w_start = i_lp + 3'd1;
        w_dbl   = {i_req, i_req};
        w_rot   = w_dbl[{1'b0, w_start} +: 8];
        w_idx   = 3'd0;
        o_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_idx   = 3'(k);
                o_valid = 1'b1;
            end
        end
        o_lvl = w_idx + w_start;
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259A control core: fully-nested priority resolution, two-pulse 8086 INTA sequence, OCW2 EOI/rotate.
// int_out and all outputs are registered; irr_clr and data_oe are single-cycle pulses.
module pic_int_sequencer
    import pic_int_sequencer_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LVL = SPURIOUS_LVL_DFLT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_irr,
    input  logic [7:0] i_imr,
    input  logic [4:0] i_vec_base,
    input  logic       i_aeoi,
    input  logic       i_inta,
    input  logic       i_ocw2_wr,
    input  logic [7:0] i_ocw2,
    output logic       o_int_out,
    output logic [7:0] o_isr,
    output logic [7:0] o_irr_clr,
    output logic [7:0] o_data_out,
    output logic       o_data_oe
);
    state_t     r_state, w_state_nxt;
    logic [7:0] r_isr, w_isr_nxt;
    logic [2:0] r_lp, w_lp_nxt;
    logic       r_rot_aeoi, w_rot_aeoi_nxt;
    logic [2:0] r_lvl, w_lvl_nxt;
    logic       r_spur, w_spur_nxt;
    logic       r_int_out, w_int_nxt;
    logic [7:0] r_irr_clr, w_irr_clr_nxt;
    logic [7:0] r_data_out, w_data_out_nxt;
    logic       r_data_oe, w_data_oe_nxt;

    logic [7:0] w_pend;
    logic       w_cand_vld, w_isr_vld, w_cand_ok;
    logic [2:0] w_cand_lvl, w_isr_hi;
    logic [7:0] w_eoi_clr, w_aeoi_clr, w_isr_set;
    logic       w_ocw_lp_wr, w_ack_lp_wr;

    assign w_pend = i_irr & ~i_imr;

    pic_priority_resolver u_pend_res (
        .i_req   (w_pend),
        .i_lp    (r_lp),
        .o_valid (w_cand_vld),
        .o_lvl   (w_cand_lvl)
    );

    pic_priority_resolver u_isr_res (
        .i_req   (r_isr),
        .i_lp    (r_lp),
        .o_valid (w_isr_vld),
        .o_lvl   (w_isr_hi)
    );

    assign w_cand_ok = w_cand_vld &&
                       (!w_isr_vld || (prio_rank(w_cand_lvl, r_lp) < prio_rank(w_isr_hi, r_lp)));

    // D4:D3 must be 00 for the byte to be an OCW2 rather than ICW1/OCW3
    always_comb begin
        w_eoi_clr      = 8'h00;
        w_ocw_lp_wr    = 1'b0;
        w_rot_aeoi_nxt = r_rot_aeoi;
        if (i_ocw2_wr && (i_ocw2[4:3] == 2'b00)) begin
            case (i_ocw2[7:5])
                OCW2_NS_EOI:       if (w_isr_vld) w_eoi_clr = onehot8(w_isr_hi);
                OCW2_SP_EOI:       w_eoi_clr = onehot8(i_ocw2[2:0]);
                OCW2_ROT_NS_EOI: begin
                    if (w_isr_vld) begin
                        w_eoi_clr   = onehot8(w_isr_hi);
                        w_ocw_lp_wr = 1'b1;
                    end
                end
                OCW2_ROT_SP_EOI: begin
                    w_eoi_clr   = onehot8(i_ocw2[2:0]);
                    w_ocw_lp_wr = 1'b1;
                end
                OCW2_SET_PRIO:     w_ocw_lp_wr = 1'b1;
                OCW2_SET_ROT_AEOI: w_rot_aeoi_nxt = 1'b1;
                OCW2_CLR_ROT_AEOI: w_rot_aeoi_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_int_nxt      = r_int_out;
        w_lvl_nxt      = r_lvl;
        w_spur_nxt     = r_spur;
        w_irr_clr_nxt  = 8'h00;
        w_data_out_nxt = r_data_out;
        w_data_oe_nxt  = 1'b0;
        w_isr_set      = 8'h00;
        w_aeoi_clr     = 8'h00;
        w_ack_lp_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_int_nxt = w_cand_ok;
                if (i_inta) begin
                    w_int_nxt   = 1'b0;
                    w_state_nxt = ST_ACK1;
                    w_spur_nxt  = !w_cand_ok;
                    if (w_cand_ok) begin
                        w_lvl_nxt     = w_cand_lvl;
                        w_isr_set     = onehot8(w_cand_lvl);
                        w_irr_clr_nxt = onehot8(w_cand_lvl);
                    end else begin
                        w_lvl_nxt = SPURIOUS_LVL;
                    end
                end
            end
            ST_ACK1: begin
                w_int_nxt = 1'b0;
                if (i_inta) begin
                    w_data_out_nxt = {i_vec_base, r_lvl};
                    w_data_oe_nxt  = 1'b1;
                    w_state_nxt    = ST_IDLE;
                    if (i_aeoi && !r_spur) begin
                        w_aeoi_clr  = onehot8(r_lvl);
                        w_ack_lp_wr = r_rot_aeoi;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // INTA/AEOI pointer update wins over a concurrent OCW2 rotate
    always_comb begin
        w_isr_nxt = (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_isr_set;
        w_lp_nxt  = r_lp;
        if (w_ack_lp_wr)      w_lp_nxt = r_lvl;
        else if (w_ocw_lp_wr) w_lp_nxt = (i_ocw2[7:5] == OCW2_ROT_NS_EOI) ? w_isr_hi : i_ocw2[2:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_isr      <= 8'h00;
            r_lp       <= LP_RESET;
            r_rot_aeoi <= 1'b0;
            r_lvl      <= 3'd0;
            r_spur     <= 1'b0;
            r_int_out  <= 1'b0;
            r_irr_clr  <= 8'h00;
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_isr      <= w_isr_nxt;
            r_lp       <= w_lp_nxt;
            r_rot_aeoi <= w_rot_aeoi_nxt;
            r_lvl      <= w_lvl_nxt;
            r_spur     <= w_spur_nxt;
            r_int_out  <= w_int_nxt;
            r_irr_clr  <= w_irr_clr_nxt;
            r_data_out <= w_data_out_nxt;
            r_data_oe  <= w_data_oe_nxt;
        end
    end

    assign o_int_out  = r_int_out;
    assign o_isr      = r_isr;
    assign o_irr_clr  = r_irr_clr;
    assign o_data_out = r_data_out;
    assign o_data_oe  = r_data_oe;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed scenarios followed by random traffic, every cycle compared against a priority-list model.
module tb_pic_int_sequencer;
    logic       clk = 1'b0;
    logic       reset, aeoi, inta, ocw2_wr;
    logic [7:0] irr, imr, ocw2;
    logic [4:0] vec_base;
    logic       int_out, data_oe;
    logic [7:0] isr, irr_clr, data_out;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_isr, m_irr_clr, m_dout;
    logic       m_int, m_oe;
    int         m_lp, m_lvl;
    bit         m_rot, m_ack, m_spur;

    pic_int_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_irr      (irr),
        .i_imr      (imr),
        .i_vec_base (vec_base),
        .i_aeoi     (aeoi),
        .i_inta     (inta),
        .i_ocw2_wr  (ocw2_wr),
        .i_ocw2     (ocw2),
        .o_int_out  (int_out),
        .o_isr      (isr),
        .o_irr_clr  (irr_clr),
        .o_data_out (data_out),
        .o_data_oe  (data_oe)
    );

    always #5 clk = ~clk;

    // walk the priority list from the top; -1 when nothing is set
    function automatic int top_of(logic [7:0] v, int lp);
        for (int p = 0; p < 8; p++) begin
            if (v[(lp + 1 + p) % 8]) return (lp + 1 + p) % 8;
        end
        return -1;
    endfunction

    function automatic int rank_of(int l, int lp);
        return (l - lp - 1 + 16) % 8;
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle();
        logic [7:0] clr, set, n_irr_clr, n_dout;
        int c, h, n_lp, n_lvl, L;
        bit cval, n_int, n_ack, n_spur, n_rot, n_oe;
        if (reset) begin
            m_isr = 8'h00; m_int = 1'b0; m_irr_clr = 8'h00; m_dout = 8'h00; m_oe = 1'b0;
            m_lp = 7; m_rot = 0; m_ack = 0; m_lvl = 0; m_spur = 0;
        end else begin
            c = top_of(irr & ~imr, m_lp);
            h = top_of(m_isr, m_lp);
            cval = (c >= 0) && ((h < 0) || (rank_of(c, m_lp) < rank_of(h, m_lp)));
            clr = 8'h00; set = 8'h00; n_irr_clr = 8'h00; n_dout = m_dout; n_oe = 0;
            n_lp = m_lp; n_rot = m_rot; n_lvl = m_lvl; n_spur = m_spur; n_ack = m_ack;
            L = int'(ocw2[2:0]);
            if (ocw2_wr) begin
                case (ocw2[7:5])
                    3'b001: if (h >= 0) clr[h] = 1'b1;
                    3'b011: clr[L] = 1'b1;
                    3'b101: if (h >= 0) begin clr[h] = 1'b1; n_lp = h; end
                    3'b111: begin clr[L] = 1'b1; n_lp = L; end
                    3'b110: n_lp = L;
                    3'b100: n_rot = 1;
                    3'b000: n_rot = 0;
                    default: ;
                endcase
            end
            if (!m_ack) begin
                n_int = cval;
                if (inta) begin
                    n_int = 0; n_ack = 1; n_spur = !cval;
                    if (cval) begin
                        n_lvl = c; set[c] = 1'b1; n_irr_clr[c] = 1'b1;
                    end else begin
                        n_lvl = 7;
                    end
                end
            end else begin
                n_int = 0;
                if (inta) begin
                    n_dout = {vec_base, 3'(m_lvl)}; n_oe = 1; n_ack = 0;
                    if (aeoi && !m_spur) begin
                        clr[m_lvl] = 1'b1;
                        if (m_rot) n_lp = m_lvl;
                    end
                end
            end
            m_isr = (m_isr & ~clr) | set;
            m_int = n_int; m_irr_clr = n_irr_clr; m_dout = n_dout; m_oe = n_oe;
            m_lp = n_lp; m_rot = n_rot; m_lvl = n_lvl; m_spur = n_spur; m_ack = n_ack;
        end
    endtask

    // one clock: predict, clock, compare, then retire strobes and emulate upstream IRR clear
    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("int_out", {7'd0, int_out}, {7'd0, m_int});
        chk("isr", isr, m_isr);
        chk("irr_clr", irr_clr, m_irr_clr);
        chk("data_oe", {7'd0, data_oe}, {7'd0, m_oe});
        chk("data_out", data_out, m_dout);
        irr = irr & ~m_irr_clr;
        inta = 1'b0; ocw2_wr = 1'b0; reset = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; irr = 8'h00; imr = 8'h00; aeoi = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; irr = 8'h00; imr = 8'h00; vec_base = 5'h08; aeoi = 1'b0;
        inta = 1'b0; ocw2_wr = 1'b0; ocw2 = 8'h00;

        // 1: basic sequence, IR2 beats IR5
        do_reset();
        chk("rst_isr", isr, 8'h00);
        chk("rst_int", {7'd0, int_out}, 8'h00);
        irr = 8'h24; step();
        chk("t1_int", {7'd0, int_out}, 8'h01);
        inta = 1'b1; step();
        chk("t1_isr", isr, 8'h04);
        chk("t1_irr_clr", irr_clr, 8'h04);
        step();
        inta = 1'b1; step();
        chk("t1_vec", data_out, 8'h42);
        chk("t1_oe", {7'd0, data_oe}, 8'h01);

        // 2: nesting, IR5/IR3 blocked by IR2 in service, IR1 raises INT
        irr = irr | 8'h08; step(); step();
        chk("t2_blocked", {7'd0, int_out}, 8'h00);
        irr = irr | 8'h02; step(); step();
        chk("t2_nest", {7'd0, int_out}, 8'h01);

        // 3: spurious
        do_reset();
        imr = 8'hFF; irr = 8'h10; step();
        inta = 1'b1; step();
        chk("t3_irr_clr", irr_clr, 8'h00);
        chk("t3_isr", isr, 8'h00);
        inta = 1'b1; step();
        chk("t3_vec", data_out, 8'h47);

        // 4: rotate on AEOI, then IR0 ranks above IR3
        do_reset();
        aeoi = 1'b1; ocw2 = 8'h80; ocw2_wr = 1'b1; step();
        irr = 8'h08; step(); step();
        inta = 1'b1; step();
        chk("t4_irr_clr", irr_clr, 8'h08);
        inta = 1'b1; step();
        chk("t4_isr", isr, 8'h00);
        chk("t4_vec", data_out, 8'h43);
        irr = 8'h09; step(); step();
        inta = 1'b1; step();
        chk("t4_first_ir0", irr_clr, 8'h01);
        inta = 1'b1; step(); step(); step();
        inta = 1'b1; step();
        chk("t4_then_ir3", irr_clr, 8'h08);
        inta = 1'b1; step();

        // 5: NS EOI then rotate-on-specific-EOI
        do_reset();
        irr = 8'h20; step(); step();
        inta = 1'b1; step(); inta = 1'b1; step();
        irr = 8'h02; step(); step();
        inta = 1'b1; step(); inta = 1'b1; step();
        chk("t5_isr22", isr, 8'h22);
        ocw2 = 8'h20; ocw2_wr = 1'b1; step();
        chk("t5_ns_eoi", isr, 8'h20);
        ocw2 = 8'hE5; ocw2_wr = 1'b1; step();
        chk("t5_rot_eoi", isr, 8'h00);
        irr = 8'h41; step(); step();
        inta = 1'b1; step();
        chk("t5_ir6", irr_clr, 8'h40);
        inta = 1'b1; step();

        // 6: reset while waiting for the second INTA
        do_reset();
        irr = 8'h10; step(); step();
        inta = 1'b1; step();
        reset = 1'b1; step();
        chk("t6_isr", isr, 8'h00);
        chk("t6_oe", {7'd0, data_oe}, 8'h00);
        chk("t6_int", {7'd0, int_out}, 8'h00);
        irr = 8'h10; step(); step();
        inta = 1'b1; step();
        chk("t6_idle", irr_clr, 8'h10);
        inta = 1'b1; step();

        // random traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) irr = irr | (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) imr = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 63) == 0) aeoi = ~aeoi;
            if ($urandom_range(0, 127) == 0) vec_base = 5'($urandom);
            inta = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) begin
                ocw2 = {3'($urandom), 2'b00, 3'($urandom)};
                ocw2_wr = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
